adc_capture: RTL and testbench

- Upstream stage of the demodulation chain; fills the adc sample BSRAM that demodulation and the fft1024 input loader consume.
- Paces MCP3002 reads at a fixed sampling rate and writes CAPTURE_LEN 10-bit samples into the single-port BSRAM, starting at a caller-supplied base address.
- Controlled by a start/done handshake from demodulation; flags late conversions.

---
 rtl/adc_pkg.sv | 20 ++
 rtl/adc_tick_gen.sv | 42 ++++
 rtl/adc_capture.sv | 172 +++++++++++++++++
 tb/tb_adc_capture.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the adc capture path: default bus widths, the
// capture state encoding and the sample-pacing divider computation.
package adc_pkg;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        WRITE = 2'd2,
        FIN   = 2'd3
    } state_e;

    // Clock cycles between samples, integer-truncated.
    function automatic int tick_div(input int clk_freq, input int sampling_freq);
        return clk_freq / sampling_freq;
    endfunction

endpackage

// File: rtl/adc_tick_gen.sv
// Reloadable down-counter that emits a one-cycle tick every DIV enabled
// cycles. load_i restarts the period; the counter holds while en_i is low.
module adc_tick_gen #(
    parameter int DIV = 527
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Count down while enabled; on reaching zero, reload and tick.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        cnt_d  = cnt_q;
        tick_o = 1'b0;
        if (load_i) begin
            cnt_d = RELOAD;
        end else if (en_i) begin
            if (cnt_q == '0) begin
                cnt_d  = RELOAD;
                tick_o = 1'b1;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values and simulation matches hardware.
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/adc_capture.sv
// Paced MCP3002 capture into the single-port sample BSRAM.
// On start, writes CAPTURE_LEN samples, one every TICK_DIV cycles, starting
// at base_addr and wrapping modulo 2^ADDR_W, then pulses done.
// Optional build macro ADC_CAPTURE_TRIGGER_EN: hold off the first write until
// a sample deviates from mid-scale by at least TRIG_THRESH (adds port armed).
module adc_capture #(
    parameter int CLK_FREQ      = 27_000_000,
    parameter int SAMPLING_FREQ = 51_200,
    parameter int ADDR_W        = adc_pkg::ADDR_W,
    parameter int DATA_W        = adc_pkg::DATA_W,
    parameter int CAPTURE_LEN   = 1024
`ifdef ADC_CAPTURE_TRIGGER_EN
    ,
    parameter int TRIG_THRESH   = 64
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              late,
`ifdef ADC_CAPTURE_TRIGGER_EN
    output logic              armed,
`endif
    output logic              adc_enable,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_available,
    output logic              adc_clear_available,
    output logic              ram_oce,
    output logic              ram_ce,
    output logic              ram_wre,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [DATA_W-1:0] ram_din
);

    import adc_pkg::*;

    localparam int TICK_DIV = tick_div(CLK_FREQ, SAMPLING_FREQ);
    localparam int CNT_W = $clog2(CAPTURE_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CAPTURE_LEN);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              late_q, late_d;
    logic              tick;
    logic              accept;
    logic              tick_en;

    // A start is only honoured from IDLE; the pacer runs through RUN and WRITE.
    assign accept  = (state_q == IDLE) && start;
    assign tick_en = (state_q == RUN) || (state_q == WRITE);

    adc_tick_gen #(
        .DIV(TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .load_i (accept),
        .en_i   (tick_en),
        .tick_o (tick)
    );

`ifdef ADC_CAPTURE_TRIGGER_EN
    localparam logic [DATA_W:0] MID    = (DATA_W + 1)'(1) << (DATA_W - 1);
    localparam logic [DATA_W:0] THRESH = (DATA_W + 1)'(TRIG_THRESH);

    logic            armed_q, armed_d;
    logic [DATA_W:0] sample_ext;
    logic [DATA_W:0] dev;
    logic            hit;

    // Distance of the current sample from mid-scale.
    assign sample_ext = {1'b0, adc_data};
    assign dev        = (sample_ext >= MID) ? (sample_ext - MID) : (MID - sample_ext);
    assign hit        = (dev >= THRESH);
    assign armed      = armed_q;

    // Armed flag: set on start, cleared by the triggering tick.
    always_ff @(posedge clk) begin
        if (rst) armed_q <= 1'b0;
        else     armed_q <= armed_d;
    end
`endif

    // Capture state, write pointer, sample counter and late flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            late_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            late_q   <= late_d;
        end
    end

    // Next-state logic and BSRAM/ADC control decode.
    always_comb begin
        state_d             = state_q;
        wr_ptr_d            = wr_ptr_q;
        cnt_d               = cnt_q;
        late_d              = late_q;
        busy                = 1'b0;
        done                = 1'b0;
        adc_enable          = 1'b0;
        adc_clear_available = 1'b0;
        ram_ce              = 1'b0;
        ram_wre             = 1'b0;
        ram_ad              = '0;
        ram_din             = '0;
`ifdef ADC_CAPTURE_TRIGGER_EN
        armed_d             = armed_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    wr_ptr_d = base_addr;
                    cnt_d    = '0;
                    late_d   = 1'b0;
`ifdef ADC_CAPTURE_TRIGGER_EN
                    armed_d  = 1'b1;
`endif
                end
            end
            RUN: begin
                busy       = 1'b1;
                adc_enable = 1'b1;
                if (tick) begin
`ifdef ADC_CAPTURE_TRIGGER_EN
                    // While armed, a tick only advances if the sample trips the threshold.
                    if (!armed_q || hit) begin
                        armed_d = 1'b0;
                        state_d = WRITE;
                    end
`else
                    state_d = WRITE;
`endif
                end
            end
            WRITE: begin
                busy                = 1'b1;
                adc_enable          = 1'b1;
                ram_ce              = 1'b1;
                ram_wre             = 1'b1;
                ram_ad              = wr_ptr_q;
                ram_din             = adc_data;
                adc_clear_available = 1'b1;
                // A stale sample is still written; the flag records that it happened.
                if (!adc_available) late_d = 1'b1;
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                cnt_d    = cnt_q + CNT_W'(1);
                state_d  = (cnt_d == LAST_CNT) ? FIN : RUN;
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ram_oce = 1'b0;
    assign late    = late_q;

endmodule

// File: tb/tb_adc_capture.sv
// Self-checking bench for adc_capture. Uses a short pacing period and capture
// length; the expected write stream is derived from the capture rules:
// write k lands k*D clock edges after the edge that accepts start, at
// (base+k-1) mod 2^ADDR_W, with whatever the ADC presented in that cycle.
// Build with ADC_CAPTURE_TRIGGER_EN to exercise the trigger variant instead.
module tb_adc_capture;

    localparam int AW    = 13;
    localparam int DW    = 10;
    localparam int D     = 7;
    localparam int N     = 16;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          busy, done, late, adc_enable;
    logic [DW-1:0] adc_data;
    logic          adc_available;
    logic          adc_clear_available;
    logic          ram_oce, ram_ce, ram_wre;
    logic [AW-1:0] ram_ad;
    logic [DW-1:0] ram_din;
`ifdef ADC_CAPTURE_TRIGGER_EN
    logic          armed;
`endif

    typedef struct {
        int edge_n;
        int addr;
        int data;
    } wr_t;

    typedef struct {
        logic [AW-1:0] base;
        int            drop_k;
        int            exp_late;
        int            exp_last;
    } vec_t;

    int  edge_cnt  = 0;
    int  n_checks  = 0;
    int  n_errors  = 0;
    int  drv_mode  = 0;
    int  drop_k    = 0;
    int  drop_pct  = 0;
    int  trig_edge = 0;
    bit  ctrl_bad  = 1'b0;
    wr_t wr_q[$];
    int  done_q[$];
    logic [DW-1:0] data_hist[int];
    bit            avail_hist[int];

    adc_capture #(
        .CLK_FREQ      (7000),
        .SAMPLING_FREQ (1000),
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .CAPTURE_LEN   (N)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .base_addr           (base_addr),
        .busy                (busy),
        .done                (done),
        .late                (late),
`ifdef ADC_CAPTURE_TRIGGER_EN
        .armed               (armed),
`endif
        .adc_enable          (adc_enable),
        .adc_data            (adc_data),
        .adc_available       (adc_available),
        .adc_clear_available (adc_clear_available),
        .ram_oce             (ram_oce),
        .ram_ce              (ram_ce),
        .ram_wre             (ram_wre),
        .ram_ad              (ram_ad),
        .ram_din             (ram_din)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Observe the BSRAM port and done pulse mid-cycle.
    always @(negedge clk) begin
        if (ram_ce && ram_wre) wr_q.push_back('{edge_cnt, int'(ram_ad), int'(ram_din)});
        if (done) done_q.push_back(edge_cnt);
        if (ram_oce || (ram_ce != ram_wre) || (adc_clear_available != (ram_ce && ram_wre)))
            ctrl_bad <= 1'b1;
    end

    // ADC model: new value shortly after each edge, history kept for the model.
    initial begin
        adc_data      = '0;
        adc_available = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (drv_mode)
                0:       adc_data = 10'h155;
                1:       adc_data = DW'($urandom);
                default: adc_data = (edge_cnt < trig_edge) ? 10'd512 : 10'd600;
            endcase
            if (drop_pct > 0) adc_available = ($urandom_range(0, 99) >= drop_pct);
            else              adc_available = !(drop_k != 0 && wr_q.size() == drop_k - 1);
            data_hist[edge_cnt]  = adc_data;
            avail_hist[edge_cnt] = adc_available;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({busy, done, late, adc_enable, adc_clear_available,
                    ram_oce, ram_ce, ram_wre, ram_ad, ram_din});
    endfunction

    task automatic wait_edge(input int target);
        do begin
            @(posedge clk);
            #1;
        end while (edge_cnt < target);
    endtask

    task automatic pulse_start(input logic [AW-1:0] b, output int e0);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = b;
        @(posedge clk);
        #1;
        start     = 1'b0;
        base_addr = '0;
        e0        = edge_cnt;
    endtask

    // One full capture, compared against the timing/address/data model.
    task automatic run_capture(input string tag, input logic [AW-1:0] b, input int dk,
                               input int mode, input int pct, input bit extra,
                               input int exp_late_tab, input int exp_last);
        int e0, ed, idx, late_m;
        wr_q.delete();
        done_q.delete();
        drop_k   = dk;
        drv_mode = mode;
        drop_pct = pct;
        pulse_start(b, e0);
        check({tag, "/busy_rise"}, busy, 1);
        if (extra) begin
            repeat (3) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        ed = e0 + N * D + 1;
        wait_edge(ed);
        if (extra) begin
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        repeat (D + 3) @(posedge clk);
        #1;
        check({tag, "/wr_count"}, wr_q.size(), N);
        idx    = 0;
        late_m = 0;
        for (int k = N - 1; k >= 0; k--) begin
            int te;
            te = e0 + (k + 1) * D;
            if (!avail_hist[te]) late_m = 1;
            if (k < wr_q.size() &&
                (wr_q[k].addr != (int'(b) + k) % DEPTH ||
                 wr_q[k].data != int'(data_hist[te]) || wr_q[k].edge_n != te))
                idx = k;
        end
        if (wr_q.size() > 0) begin
            check({tag, "/wr_addr"}, wr_q[idx].addr, (int'(b) + idx) % DEPTH);
            check({tag, "/wr_data"}, wr_q[idx].data, int'(data_hist[e0 + (idx + 1) * D]));
            check({tag, "/wr_time"}, wr_q[idx].edge_n, e0 + (idx + 1) * D);
        end
        if (exp_last >= 0)
            check({tag, "/last_addr"}, (wr_q.size() == N) ? wr_q[N-1].addr : -1, exp_last);
        check({tag, "/done_count"}, done_q.size(), 1);
        check({tag, "/done_time"}, (done_q.size() > 0) ? done_q[0] : -1, ed);
        check({tag, "/late"}, late, late_m);
        if (exp_late_tab >= 0) check({tag, "/late_tab"}, late, exp_late_tab);
        check({tag, "/idle_busy"}, busy, 0);
    endtask

    // Reset partway through a capture: outputs drop at once, writes stop.
    task automatic reset_midway();
        int e0;
        wr_q.delete();
        done_q.delete();
        drv_mode = 0;
        drop_k   = 0;
        drop_pct = 0;
        pulse_start(13'd40, e0);
        wait_edge(e0 + 10 * D);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid/outputs", out_vec(), 0);
        rst = 1'b0;
        repeat (3 * D) @(posedge clk);
        #1;
        check("rst_mid/writes", wr_q.size(), 10);
        check("rst_mid/done", done_q.size(), 0);
        check("rst_mid/busy", busy, 0);
    endtask

`ifdef ADC_CAPTURE_TRIGGER_EN
    // Mid-scale samples for ten ticks, then 600: the first write is 600.
    task automatic trigger_test();
        int e0;
        wr_q.delete();
        done_q.delete();
        drop_k    = 0;
        drop_pct  = 0;
        trig_edge = 32'h7fff_ffff;
        drv_mode  = 2;
        pulse_start(13'd50, e0);
        trig_edge = e0 + 10 * D;
        check("trig/armed_start", armed, 1);
        wait_edge(e0 + 10 * D);
        check("trig/armed_wait", armed, 1);
        check("trig/no_write_yet", wr_q.size(), 0);
        wait_edge(e0 + (10 + N) * D + 1);
        repeat (D + 3) @(posedge clk);
        #1;
        check("trig/wr_count", wr_q.size(), N);
        check("trig/first_data", (wr_q.size() > 0) ? wr_q[0].data : -1, 600);
        check("trig/first_addr", (wr_q.size() > 0) ? wr_q[0].addr : -1, 50);
        check("trig/first_time", (wr_q.size() > 0) ? wr_q[0].edge_n : -1, e0 + 11 * D);
        check("trig/done_count", done_q.size(), 1);
        check("trig/armed_end", armed, 0);
    endtask
`endif

    initial begin
        vec_t vecs[4];
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        vecs[0] = '{13'd0,    0, 0, 15};
        vecs[1] = '{13'd8185, 0, 0, 8};
        vecs[2] = '{13'd100,  5, 1, 115};
        vecs[3] = '{13'd8191, 0, 0, 14};
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset/outputs", out_vec(), 0);
        @(posedge clk);
        #1 rst = 1'b0;
`ifdef ADC_CAPTURE_TRIGGER_EN
        trigger_test();
`else
        foreach (vecs[i])
            run_capture($sformatf("vec%0d", i), vecs[i].base, vecs[i].drop_k, 0, 0, 1'b0,
                        vecs[i].exp_late, vecs[i].exp_last);
        run_capture("start_ignored", 13'd500, 0, 1, 0, 1'b1, 0, 515);
        reset_midway();
        run_capture("after_reset", 13'd8000, 0, 0, 0, 1'b0, 0, 8015);
        for (int i = 0; i < 6; i++)
            run_capture($sformatf("rand%0d", i), AW'($urandom_range(0, DEPTH - 1)), 0, 1,
                        (i % 2) * 25, 1'b0, -1, -1);
`endif
        check("ctrl_pins", ctrl_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
